ram_scan_reader: RTL and testbench

Sequential read-out engine for the 32x4 switch-programmed RAM: on a start pulse it walks a contiguous address range, reads each nibble, and streams it out over a valid/ready interface. It is the automated reader complementing the manual switch/button write path, and drives the RAM's address input in place of the switches during a scan. Downstream consumers are LED/7-segment display sequencers or a serial transmitter.

---
 rtl/ram_scan_pkg.sv | 16 +
 rtl/ram32x4.sv | 19 +
 rtl/ram_scan_csum.sv | 29 ++
 rtl/ram_scan_reader.sv | 117 +++++++++++
 tb/tb_ram_scan_reader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types and constants for the RAM scan reader slice.
// FSM state encoding, default geometry, checksum width.
package ram_scan_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;
  localparam int CSUM_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/ram32x4.sv
// Switch-programmed 32x4 RAM: synchronous write, combinational read.
// Ports: i_clk, i_we, i_addr, i_wdata in; o_rdata out.
module ram32x4 (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [4:0] i_addr,
  input  logic [3:0] i_wdata,
  output logic [3:0] o_rdata
);

  logic [3:0] r_mem [32];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_scan_csum.sv
// Running 8-bit sum of transferred words, cleared on scan start.
// Ports: i_clk, i_rst_n, i_clr, i_en, i_data in; o_sum out.
module ram_scan_csum
  import ram_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [CSUM_W-1:0] o_sum
);

  logic [CSUM_W-1:0] r_sum;
  logic [CSUM_W-1:0] w_ext;

  assign w_ext = {{(CSUM_W-DATA_W){1'b0}}, i_data};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sum <= '0;
    else if (i_clr) r_sum <= '0;
    else if (i_en) r_sum <= r_sum + w_ext;
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/ram_scan_reader.sv
// Walks a RAM address range and streams words over valid/ready.
// Ports: i_clk, i_rst_n, i_start, i_start_addr, i_count, i_rd_data,
//   i_out_ready in; o_busy, o_done, o_rd_addr, o_out_valid,
//   o_out_data, o_out_addr, o_checksum out.
// Macro SCAN_CHECKSUM_EN enables the checksum; otherwise it is 0.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W:0]   i_count,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [CSUM_W-1:0] o_checksum
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  scan_state_t       r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W:0]   r_remaining;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_remaining <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_rd_addr   <= i_start_addr;
            r_remaining <= (i_count == '0) ? FULL : i_count;
            r_busy      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          r_out_data <= i_rd_data;
          r_out_addr <= r_rd_addr;
          r_valid    <= 1'b1;
          r_state    <= PRESENT;
        end
        PRESENT: begin
          if (i_out_ready) begin
            r_valid     <= 1'b0;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == 1) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_rd_addr <= r_rd_addr + 1'b1;
              r_state   <= FETCH;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_out_valid = r_valid;
  assign o_rd_addr   = r_rd_addr;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;

`ifdef SCAN_CHECKSUM_EN
  logic w_hs;
  logic w_clr;

  // Valid is high exactly in PRESENT, so this is the handshake.
  assign w_hs  = (r_state == PRESENT) && i_out_ready;
  assign w_clr = (r_state == IDLE) && i_start;

  ram_scan_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_en    (w_hs),
    .i_data  (r_out_data),
    .o_sum   (o_checksum)
  );
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomized self-checking bench for ram_scan_reader.
// Reference model: memory array plus expected address/data queues.
module tb_ram_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] start_addr;
  logic [5:0] count;
  logic       out_ready;
  logic       busy, done, out_valid;
  logic [4:0] rd_addr, out_addr;
  logic [3:0] rd_data, out_data;
  logic [7:0] checksum;
  logic       ld_we;
  logic [4:0] ld_addr;
  logic [3:0] ld_data;
  logic [4:0] ram_addr;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [32];
  int qa[$];
  int qd[$];

  always #5 clk = ~clk;

  assign ram_addr = ld_we ? ld_addr : rd_addr;

  ram32x4 u_ram (
    .i_clk   (clk),
    .i_we    (ld_we),
    .i_addr  (ram_addr),
    .i_wdata (ld_data),
    .o_rdata (rd_data)
  );

  ram_scan_reader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_count      (count),
    .o_busy       (busy),
    .o_done       (done),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_addr   (out_addr),
    .o_checksum   (checksum)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_csum(input int s);
`ifdef SCAN_CHECKSUM_EN
    return s;
`else
    return 0 * s;
`endif
  endfunction

  task automatic chk_reset_vals(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_valid"}, out_valid, 0);
    chk({p, "_rd_addr"}, rd_addr, 0);
    chk({p, "_out_data"}, out_data, 0);
    chk({p, "_out_addr"}, out_addr, 0);
    chk({p, "_csum"}, checksum, 0);
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = a[4:0];
    ld_data = d[3:0];
    @(posedge clk);
    #1 ld_we = 1'b0;
    mem[a] = d[3:0];
  endtask

  // mode 0: ready tied 1; 1: random ready; 2: 5-cycle stall on first word
  task automatic run_scan(input int sa, input int cnt,
                          input int mode, input bit glitch);
    int n, k, stall_left, csum, budget;
    bit prev_stall, done_seen;
    logic [4:0] pa;
    logic [3:0] pd;
    qa.delete();
    qd.delete();
    n = (cnt == 0) ? 32 : cnt;
    for (int i = 0; i < n; i++) begin
      qa.push_back((sa + i) % 32);
      qd.push_back(int'(mem[(sa + i) % 32]));
    end
    @(negedge clk);
    start_addr = sa[4:0];
    count      = cnt[5:0];
    start      = 1'b1;
    @(posedge clk);
    k = 0; csum = 0; done_seen = 0; prev_stall = 0;
    stall_left = 5; pa = '0; pd = '0;
    budget = 8 * n + 20;
    while (!done_seen && k < budget) begin
      @(negedge clk);
      start = 1'b0;
      if (glitch) begin
        start      = 1'($urandom_range(0, 1));
        start_addr = 5'($urandom);
        count      = 6'($urandom);
        if (done) start = 1'b1;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
      endcase
      chk("busy_scan", busy, 1);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", out_addr, pa);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && out_ready) begin
        chk("word_avail", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          chk("out_addr", out_addr, qa[0]);
          chk("out_data", out_data, qd[0]);
          csum = (csum + qd[0]) % 256;
          void'(qa.pop_front());
          void'(qd.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
      if (done) begin
        done_seen = 1;
        chk("words_left", qa.size(), 0);
        if (mode == 0) chk("done_cycle", k, 2 * n);
        chk("csum_done", checksum, exp_csum(csum));
      end
      k++;
    end
    chk("done_seen", done_seen, 1);
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_csum", checksum, exp_csum(csum));
    @(negedge clk);
    chk("idle2_busy", busy, 0);
    chk("idle2_done", done, 0);
    chk("idle2_csum", checksum, exp_csum(csum));
  endtask

  task automatic reset_mid_scan();
    @(negedge clk);
    start_addr = 5'd3;
    count      = 6'd10;
    out_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    count = '0;
    out_ready = 1'b0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) wr(a, a % 16);

    run_scan(0, 4, 0, 0);
    run_scan(30, 4, 0, 0);
    run_scan(0, 0, 0, 0);
    run_scan(5, 3, 2, 0);
    reset_mid_scan();
    run_scan(7, 10, 0, 0);
    run_scan(10, 6, 0, 1);

    for (int a = 0; a < 32; a++) wr(a, int'($urandom_range(0, 15)));
    for (int t = 0; t < 8; t++) begin
      run_scan(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
